// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 responder with a synchronous single-port word memory
`timescale 1ns/1ps
module axi_mem_responder #(
    parameter int unsigned MEM_SIZE  = 2**16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter              INIT_FILE = ""
) (
    input  logic        i_aclk,
    input  logic        i_areset_n,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [1:0]  i_awburst,
    input  logic [2:0]  i_awsize,
    input  logic [7:0]  i_awlen,
    input  logic [31:0] i_awaddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    input  logic [1:0]  i_arburst,
    input  logic [2:0]  i_arsize,
    input  logic [7:0]  i_arlen,
    input  logic [31:0] i_araddr,
    input  logic        i_wvalid,
    output logic        o_wready,
    input  logic        i_wlast,
    input  logic [7:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic [1:0]  o_bresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic        o_rlast,
    output logic [31:0] o_rdata
);

    localparam int unsigned WORDS = MEM_SIZE / 4;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_DATA,
        S_W_RESP,
        S_R_FETCH,
        S_R_VALID
    } state_t;

    state_t      state_q;
    logic        prio_w_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic [2:0]  size_q;
    logic [8:0]  cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        rlast_q;

    logic [31:0] mem_q [0:WORDS-1];

    logic [31:0] off;
    logic        in_range;
    logic [IW-1:0] idx;
    logic        beat_last;
    logic [31:0] next_addr;
    logic        mem_we;
    logic        idle;

    // Offset arithmetic wraps, so a window ending at the top of the address space still works.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = {1'b0, off} < 33'(MEM_SIZE);
    assign idx       = off[IW+1:2];
    assign beat_last = (cnt_q == {1'b0, len_q});
    assign next_addr = (burst_q == 2'd0) ? addr_q : addr_q + 32'd4;

    assign idle      = (state_q == S_IDLE);
    assign o_awready = idle & i_awvalid & (~i_arvalid | prio_w_q);
    assign o_arready = idle & i_arvalid & (~i_awvalid | ~prio_w_q);
    assign o_wready  = (state_q == S_W_DATA);
    assign o_bvalid  = (state_q == S_W_RESP);
    assign o_bresp   = (o_bvalid && (err_q || size_q != 3'd2)) ? 2'b10 : 2'b00;
    assign o_rvalid  = (state_q == S_R_VALID);
    assign o_rlast   = rlast_q;
    assign o_rdata   = rdata_q;

    assign mem_we = (state_q == S_W_DATA) && i_wvalid && in_range;

    logic unused_ok;
    assign unused_ok = &{1'b0, off, i_wstrb[7:4], i_arsize};

    // Memory sits outside the reset domain so its contents survive reset.
    always_ff @(posedge i_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= S_IDLE;
            prio_w_q <= 1'b1;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (o_awready) begin
                        addr_q   <= i_awaddr;
                        len_q    <= i_awlen;
                        burst_q  <= i_awburst;
                        size_q   <= i_awsize;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        prio_w_q <= ~prio_w_q;
                        state_q  <= S_W_DATA;
                    end else if (o_arready) begin
                        addr_q   <= i_araddr;
                        len_q    <= i_arlen;
                        burst_q  <= i_arburst;
                        size_q   <= i_arsize;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        prio_w_q <= ~prio_w_q;
                        state_q  <= S_R_FETCH;
                    end
                end
                S_W_DATA: begin
                    if (i_wvalid) begin
                        if (!in_range || (i_wlast != beat_last)) begin
                            err_q <= 1'b1;
                        end
                        if (beat_last) begin
                            state_q <= S_W_RESP;
                        end else begin
                            cnt_q  <= cnt_q + 9'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                S_W_RESP: begin
                    if (i_bready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_R_FETCH: begin
                    rdata_q <= in_range ? mem_q[idx] : 32'd0;
                    rlast_q <= beat_last;
                    state_q <= S_R_VALID;
                end
                S_R_VALID: begin
                    if (i_rready) begin
                        if (rlast_q) begin
                            rlast_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 9'd1;
                            addr_q  <= next_addr;
                            state_q <= S_R_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
`timescale 1ns/1ps
module tb_axi_mem_responder;

    logic        i_aclk;
    logic        i_areset_n;
    logic        i_awvalid, o_awready;
    logic [1:0]  i_awburst;
    logic [2:0]  i_awsize;
    logic [7:0]  i_awlen;
    logic [31:0] i_awaddr;
    logic        i_arvalid, o_arready;
    logic [1:0]  i_arburst;
    logic [2:0]  i_arsize;
    logic [7:0]  i_arlen;
    logic [31:0] i_araddr;
    logic        i_wvalid, o_wready, i_wlast;
    logic [7:0]  i_wstrb;
    logic [31:0] i_wdata;
    logic        o_bvalid, i_bready;
    logic [1:0]  o_bresp;
    logic        o_rvalid, i_rready, o_rlast;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b [$];
    logic [32:0] exp_r [$];

    logic [31:0] wdat [8];
    logic [3:0]  wstb [8];
    logic [31:0] rexp [8];

    axi_mem_responder dut (
        .i_aclk(i_aclk), .i_areset_n(i_areset_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awburst(i_awburst),
        .i_awsize(i_awsize), .i_awlen(i_awlen), .i_awaddr(i_awaddr),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arburst(i_arburst),
        .i_arsize(i_arsize), .i_arlen(i_arlen), .i_araddr(i_araddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wlast(i_wlast),
        .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rlast(o_rlast), .o_rdata(o_rdata)
    );

    initial begin
        i_aclk = 1'b0;
        forever #5 i_aclk = ~i_aclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshakes are visible on the falling edge before they complete.
    always @(negedge i_aclk) begin
        if (i_areset_n && o_bvalid && i_bready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL bresp: unexpected response %0d, required none", o_bresp);
            end else begin
                logic [1:0] e;
                e = exp_b.pop_front();
                if (o_bresp !== e) begin
                    errors++;
                    $display("FAIL bresp: got %0d, required %0d", o_bresp, e);
                end
            end
        end
        if (i_areset_n && o_rvalid && i_rready) begin
            checks++;
            if (exp_r.size() == 0) begin
                errors++;
                $display("FAIL rbeat: unexpected beat 0x%08h, required none", o_rdata);
            end else begin
                logic [32:0] e;
                e = exp_r.pop_front();
                if ({o_rlast, o_rdata} !== e) begin
                    errors++;
                    $display("FAIL rbeat: got last=%0b data=0x%08h, required last=%0b data=0x%08h",
                             o_rlast, o_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic wait_ready(input int sel, input string name);
        logic r;
        bit   ok;
        ok = 0;
        for (int t = 0; t < 64; t++) begin
            #1;
            case (sel)
                0:       r = o_awready;
                1:       r = o_arready;
                2:       r = o_wready;
                default: r = o_bvalid;
            endcase
            @(posedge i_aclk);
            if (r) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_handshake: got no ready in 64 cycles, required handshake", name);
        end
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size);
        i_awaddr = a; i_awlen = len; i_awburst = burst; i_awsize = size;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        i_araddr = a; i_arlen = len; i_arburst = burst; i_arsize = 3'd2;
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size);
        set_aw(a, len, burst, size);
        i_awvalid = 1'b1;
        wait_ready(0, "aw");
        #1;
        i_awvalid = 1'b0;
        chk("wready_latency", 32'(o_wready), 32'd1);
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        set_ar(a, len, burst);
        i_arvalid = 1'b1;
        wait_ready(1, "ar");
        #1;
        i_arvalid = 1'b0;
        chk("rvalid_early", 32'(o_rvalid), 32'd0);
    endtask

    task automatic w_phase(input int n, input int wlast_at, input logic [1:0] resp);
        exp_b.push_back(resp);
        for (int i = 0; i < n; i++) begin
            i_wvalid = 1'b1;
            i_wdata  = wdat[i];
            i_wstrb  = {4'hA, wstb[i]};
            i_wlast  = (i == wlast_at);
            wait_ready(2, "w");
            #1;
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
        chk("bvalid_latency", 32'(o_bvalid), 32'd1);
        i_bready = 1'b1;
        wait_ready(3, "b");
        #1;
        i_bready = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 32'({o_awready, o_arready, o_wready, o_bvalid, o_bresp, o_rvalid, o_rlast}), 32'd0);
        chk({name, "_rdata"}, o_rdata, 32'd0);
    endtask

    task automatic r_phase(input int n, input int stall, input int abort);
        int  b, stallc, t;
        bit  seen;
        for (int i = 0; i < n; i++) begin
            if (abort < 0 || i < abort) exp_r.push_back({(i == n - 1), rexp[i]});
        end
        b = 0; stallc = 0; t = 0; seen = 0;
        while (b < n && t < 100) begin
            @(posedge i_aclk);
            #1;
            t++;
            i_rready = 1'b0;
            if (o_rvalid) begin
                if (!seen) begin
                    seen = 1;
                    chk("rvalid_latency", 32'(t), 32'd1);
                end
                if (b == abort) begin
                    i_areset_n = 1'b0;
                    #1;
                    chk_outputs_zero("reset_mid_read");
                    repeat (2) @(negedge i_aclk);
                    i_areset_n = 1'b1;
                    @(posedge i_aclk);
                    #1;
                    return;
                end
                if (b == stall && stallc < 3) begin
                    if (stallc > 0) begin
                        chk("stall_rdata", o_rdata, rexp[b]);
                        chk("stall_rlast", 32'(o_rlast), 32'(b == n - 1));
                    end
                    stallc++;
                end else begin
                    i_rready = 1'b1;
                    b++;
                end
            end
        end
        @(posedge i_aclk);
        #1;
        i_rready = 1'b0;
        checks++;
        if (b < n) begin
            errors++;
            $display("FAIL read_beats: got %0d beats, required %0d", b, n);
        end
    endtask

    task automatic read1(input logic [31:0] a, input logic [31:0] d);
        rexp[0] = d;
        ar_phase(a, 8'd0, 2'd1);
        r_phase(1, -1, -1);
    endtask

    initial begin
        i_areset_n = 1'b0;
        i_awvalid = 0; i_awburst = 0; i_awsize = 0; i_awlen = 0; i_awaddr = 0;
        i_arvalid = 0; i_arburst = 0; i_arsize = 0; i_arlen = 0; i_araddr = 0;
        i_wvalid = 0; i_wlast = 0; i_wstrb = 0; i_wdata = 0;
        i_bready = 0; i_rready = 0;
        #1;
        chk_outputs_zero("reset_state");
        repeat (2) @(negedge i_aclk);
        i_areset_n = 1'b1;
        @(posedge i_aclk);
        #1;

        // Simultaneous AW/AR out of reset: write wins.
        set_aw(32'h10, 8'd0, 2'd1, 3'd2);
        set_ar(32'h10, 8'd0, 2'd1);
        i_awvalid = 1'b1;
        i_arvalid = 1'b1;
        #1;
        chk("arb1_awready", 32'(o_awready), 32'd1);
        chk("arb1_arready", 32'(o_arready), 32'd0);
        wait_ready(0, "aw");
        #1;
        i_awvalid = 1'b0;
        i_arvalid = 1'b0;
        chk("wready_latency", 32'(o_wready), 32'd1);
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        w_phase(1, 0, 2'b00);

        // Second simultaneous pair: read wins.
        set_aw(32'h0, 8'd0, 2'd1, 3'd2);
        set_ar(32'h10, 8'd0, 2'd1);
        i_awvalid = 1'b1;
        i_arvalid = 1'b1;
        #1;
        chk("arb2_arready", 32'(o_arready), 32'd1);
        chk("arb2_awready", 32'(o_awready), 32'd0);
        wait_ready(1, "ar");
        #1;
        i_awvalid = 1'b0;
        i_arvalid = 1'b0;
        chk("rvalid_early", 32'(o_rvalid), 32'd0);
        rexp[0] = 32'hDEADBEEF;
        r_phase(1, -1, -1);

        aw_phase(32'h0, 8'd0, 2'd1, 3'd2);
        wdat[0] = 32'h12345678; wstb[0] = 4'hF;
        w_phase(1, 0, 2'b00);

        // INCR burst with a 3-cycle stall on beat 2.
        aw_phase(32'h100, 8'd3, 2'd1, 3'd2);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 1); wstb[i] = 4'hF; rexp[i] = 32'(i + 1);
        end
        w_phase(4, 3, 2'b00);
        ar_phase(32'h100, 8'd3, 2'd1);
        r_phase(4, 1, -1);

        // Byte strobes over a FIXED burst.
        aw_phase(32'h20, 8'd0, 2'd1, 3'd2);
        wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
        w_phase(1, 0, 2'b00);
        aw_phase(32'h20, 8'd1, 2'd0, 3'd2);
        wdat[0] = 32'h000000AA; wstb[0] = 4'h1;
        wdat[1] = 32'h0000BB00; wstb[1] = 4'h2;
        w_phase(2, 1, 2'b00);
        read1(32'h20, 32'hFFFFBBAA);

        // Non-word awsize still writes but answers SLVERR.
        aw_phase(32'h30, 8'd0, 2'd1, 3'd1);
        wdat[0] = 32'h00000055; wstb[0] = 4'hF;
        w_phase(1, 0, 2'b10);
        read1(32'h30, 32'h00000055);

        // Burst running off the top of memory.
        aw_phase(32'hFFFC, 8'd1, 2'd1, 3'd2);
        wdat[0] = 32'hA5A5A5A5; wstb[0] = 4'hF;
        wdat[1] = 32'h5A5A5A5A; wstb[1] = 4'hF;
        w_phase(2, 1, 2'b10);
        rexp[0] = 32'hA5A5A5A5; rexp[1] = 32'h0;
        ar_phase(32'hFFFC, 8'd1, 2'd1);
        r_phase(2, -1, -1);
        read1(32'h0, 32'h12345678);

        // Early wlast: all beats still consumed and written.
        aw_phase(32'h300, 8'd2, 2'd1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            wdat[i] = 32'(i + 7); wstb[i] = 4'hF; rexp[i] = 32'(i + 7);
        end
        w_phase(3, 0, 2'b10);
        ar_phase(32'h300, 8'd2, 2'd1);
        r_phase(3, -1, -1);

        // Reset during beat 2 of a len-7 read.
        rexp[0] = 32'd1;
        ar_phase(32'h100, 8'd7, 2'd1);
        r_phase(8, -1, 1);
        chk_outputs_zero("after_reset");
        read1(32'h10, 32'hDEADBEEF);
        read1(32'h104, 32'd2);

        repeat (3) @(posedge i_aclk);
        chk("b_queue_left", 32'(exp_b.size()), 32'd0);
        chk("r_queue_left", 32'(exp_r.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
